// File: rtl/qbus_pkg.sv
// qbus_pkg: shared constants and types for the DL11-compatible console slave.
// Holds the default register block base and vector, the register offsets
// (word index taken from address bits 2:1), the status bit positions and the
// bus FSM state encoding.
package qbus_pkg;

    localparam logic [15:0] DEF_BASE = 16'o177560;
    localparam logic [15:0] DEF_VEC  = 16'o000060;

    // Word index within the register block (address bits 2:1).
    localparam logic [1:0] OFF_RCSR = 2'd0;
    localparam logic [1:0] OFF_RBUF = 2'd1;
    localparam logic [1:0] OFF_XCSR = 2'd2;
    localparam logic [1:0] OFF_XBUF = 2'd3;

    localparam int BIT_DONE  = 7;
    localparam int BIT_READY = 7;
    localparam int BIT_IE    = 6;
    localparam int BIT_ERR   = 15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_RD,
        ST_WR,
        ST_IAK,
        ST_PASS,
        ST_DONE
    } bus_state_t;

endpackage

// File: rtl/qbus_dl11_if.sv
// qbus_dl11_if: QBUS signal bundle between the processor (master) and the
// console slave. All strobes and the AD bus are active-low / inverted, exactly
// as they appear on the backplane.
//   pin_ad_in_n   inverted AD bus as seen by the slave
//   pin_ad_out_n  inverted AD data from the slave, valid when pin_ad_oe=1
//   pin_ad_oe     slave AD output enable
//   pin_sync_n, pin_din_n, pin_dout_n, pin_wtbt_n  bus strobes
//   pin_iaki_n / pin_iako_n  interrupt acknowledge daisy chain in / out
//   pin_rply_n    slave reply
//   pin_virq_n    interrupt request
interface qbus_dl11_if;

    logic [15:0] pin_ad_in_n;
    logic [15:0] pin_ad_out_n;
    logic        pin_ad_oe;
    logic        pin_sync_n;
    logic        pin_din_n;
    logic        pin_dout_n;
    logic        pin_wtbt_n;
    logic        pin_iaki_n;
    logic        pin_iako_n;
    logic        pin_rply_n;
    logic        pin_virq_n;

    modport master (
        output pin_ad_in_n, pin_sync_n, pin_din_n, pin_dout_n, pin_wtbt_n, pin_iaki_n,
        input  pin_ad_out_n, pin_ad_oe, pin_iako_n, pin_rply_n, pin_virq_n
    );

    modport slave (
        input  pin_ad_in_n, pin_sync_n, pin_din_n, pin_dout_n, pin_wtbt_n, pin_iaki_n,
        output pin_ad_out_n, pin_ad_oe, pin_iako_n, pin_rply_n, pin_virq_n
    );

endinterface

// File: rtl/qbus_sync.sv
// qbus_sync: WIDTH-bit two-flop synchronizer for asynchronous bus strobes.
// Flops reset to 1 so every active-low strobe reads as deasserted out of reset.
//   clk  system clock
//   rst  asynchronous active-high reset
//   d    asynchronous input
//   q    synchronized output
module qbus_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/qbus_dl11.sv
// qbus_dl11: QBUS console serial-line slave with a DL11 register set.
// Decodes RCSR/RBUF/XCSR/XBUF at BASE..BASE+6, answers DIN/DOUT with RPLY,
// requests interrupts for receive-done / transmit-ready, supplies VEC or VEC+4
// on interrupt acknowledge and passes IAK down the chain when idle.
//   pin_clk, pin_rst  system clock, async active-high reset
//   bus               QBUS slave modport (inverted AD, strobes, RPLY, VIRQ, IAK chain)
//   rx_data, rx_stb   received byte and its one-cycle strobe
//   tx_data, tx_valid, tx_ready  byte-side transmit handshake
//
// state | meaning
// IDLE  | no bus cycle; wait for SYNC or an acknowledge
// ADDR  | address latched; wait for DIN/DOUT (or SYNC release if unselected)
// RD    | read data on AD; RPLY asserted on exit
// WR    | register written, RPLY asserted
// IAK   | vector on AD; RPLY asserted and request cleared on exit
// PASS  | nothing pending; IAKO follows IAKI until it releases
// DONE  | hold RPLY/AD until the strobe releases, then wait for SYNC high
module qbus_dl11
    import qbus_pkg::*;
#(
    parameter logic [15:0] BASE = DEF_BASE,
    parameter logic [15:0] VEC  = DEF_VEC
) (
    input  logic        pin_clk,
    input  logic        pin_rst,
    qbus_dl11_if.slave  bus,
    input  logic [7:0]  rx_data,
    input  logic        rx_stb,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam logic [15:0] VEC_TX = VEC + 16'd4;

    logic [4:0]  s_raw;
    logic [4:0]  s_q;
    logic        s_sync_n, s_din_n, s_dout_n, s_wtbt_n, s_iaki_n;

    bus_state_t  state, nxt_state;
    logic [15:0] addr_q;
    logic [1:0]  reg_sel;
    logic        sel;
    logic        iak_tx, nxt_iak_tx;

    logic        ad_oe_q, nxt_ad_oe;
    logic [15:0] ad_out_q, nxt_ad_out_n;
    logic        rply_q, nxt_rply_n;
    logic        iako_q, nxt_iako_n;

    logic        addr_ld, wr_en, rbuf_rd, clr_rx, clr_tx;
    logic [15:0] rd_data;

    logic [7:0]  rbuf;
    logic        done, err, rx_ie, ready, tx_ie;
    logic        rx_cond, tx_cond, rx_cond_q, tx_cond_q;
    logic        rq_rx, rq_tx;

    assign s_raw = {bus.pin_sync_n, bus.pin_din_n, bus.pin_dout_n, bus.pin_wtbt_n, bus.pin_iaki_n};

    qbus_sync #(.WIDTH(5)) u_sync (
        .clk (pin_clk),
        .rst (pin_rst),
        .d   (s_raw),
        .q   (s_q)
    );

    assign {s_sync_n, s_din_n, s_dout_n, s_wtbt_n, s_iaki_n} = s_q;

    assign reg_sel = addr_q[2:1];
    assign sel     = (addr_q[15:3] == BASE[15:3]);

    always_comb begin
        rd_data = '0;
        case (reg_sel)
            OFF_RCSR: begin
                rd_data[BIT_DONE] = done;
                rd_data[BIT_IE]   = rx_ie;
            end
            OFF_RBUF: begin
                rd_data[BIT_ERR]  = err;
                rd_data[7:0]      = rbuf;
            end
            OFF_XCSR: begin
                rd_data[BIT_READY] = ready;
                rd_data[BIT_IE]    = tx_ie;
            end
            default: ;
        endcase
    end

    always_ff @(posedge pin_clk or posedge pin_rst) begin
        if (pin_rst) begin
            state    <= ST_IDLE;
            addr_q   <= '0;
            iak_tx   <= 1'b0;
            ad_oe_q  <= 1'b0;
            ad_out_q <= '1;
            rply_q   <= 1'b1;
            iako_q   <= 1'b1;
        end else begin
            state    <= nxt_state;
            iak_tx   <= nxt_iak_tx;
            ad_oe_q  <= nxt_ad_oe;
            ad_out_q <= nxt_ad_out_n;
            rply_q   <= nxt_rply_n;
            iako_q   <= nxt_iako_n;
            if (addr_ld) begin
                addr_q <= ~bus.pin_ad_in_n;
            end
        end
    end

    always_comb begin
        nxt_state    = state;
        nxt_iak_tx   = iak_tx;
        nxt_ad_oe    = ad_oe_q;
        nxt_ad_out_n = ad_out_q;
        nxt_rply_n   = rply_q;
        nxt_iako_n   = iako_q;
        addr_ld      = 1'b0;
        wr_en        = 1'b0;
        rbuf_rd      = 1'b0;
        clr_rx       = 1'b0;
        clr_tx       = 1'b0;
        case (state)
            ST_IDLE, ST_ADDR: begin
                if (state == ST_ADDR && sel && !s_din_n) begin
                    nxt_state    = ST_RD;
                    nxt_ad_oe    = 1'b1;
                    nxt_ad_out_n = ~rd_data;
                end else if (state == ST_ADDR && sel && !s_dout_n) begin
                    nxt_state  = ST_WR;
                    nxt_rply_n = 1'b0;
                    // A byte write to the odd byte is acknowledged but has no effect.
                    wr_en      = !(!s_wtbt_n && addr_q[0]);
                end else if (!s_din_n && !s_iaki_n) begin
                    if (rq_rx || rq_tx) begin
                        nxt_state    = ST_IAK;
                        nxt_ad_oe    = 1'b1;
                        nxt_ad_out_n = ~(rq_rx ? VEC : VEC_TX);
                        nxt_iak_tx   = !rq_rx;
                    end else begin
                        nxt_state  = ST_PASS;
                        nxt_iako_n = 1'b0;
                    end
                end else if (state == ST_IDLE && !s_sync_n) begin
                    nxt_state = ST_ADDR;
                    addr_ld   = 1'b1;
                end else if (state == ST_ADDR && s_sync_n) begin
                    nxt_state = ST_IDLE;
                end
            end
            ST_RD: begin
                nxt_rply_n = 1'b0;
                rbuf_rd    = (reg_sel == OFF_RBUF);
                nxt_state  = ST_DONE;
            end
            ST_WR: begin
                nxt_state = ST_DONE;
            end
            ST_IAK: begin
                nxt_rply_n = 1'b0;
                clr_rx     = !iak_tx;
                clr_tx     = iak_tx;
                nxt_state  = ST_DONE;
            end
            ST_PASS: begin
                if (s_iaki_n) begin
                    nxt_iako_n = 1'b1;
                    nxt_state  = ST_IDLE;
                end
            end
            ST_DONE: begin
                if (s_din_n && s_dout_n) begin
                    nxt_rply_n   = 1'b1;
                    nxt_ad_oe    = 1'b0;
                    nxt_ad_out_n = '1;
                    if (s_sync_n) begin
                        nxt_state = ST_IDLE;
                    end
                end
            end
            default: nxt_state = ST_IDLE;
        endcase
    end

    assign rx_cond = done & rx_ie;
    assign tx_cond = ready & tx_ie;

    always_ff @(posedge pin_clk or posedge pin_rst) begin
        if (pin_rst) begin
            rbuf      <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            rx_ie     <= 1'b0;
            ready     <= 1'b1;
            tx_ie     <= 1'b0;
            tx_data   <= '0;
            tx_valid  <= 1'b0;
            rx_cond_q <= 1'b0;
            tx_cond_q <= 1'b0;
            rq_rx     <= 1'b0;
            rq_tx     <= 1'b0;
        end else begin
            // A new byte arriving on the same edge as an RBUF read wins: DONE
            // stays set and the overrun flag is cleared by the read.
            if (rx_stb) begin
                rbuf <= rx_data;
                done <= 1'b1;
                err  <= !rbuf_rd && (err || done);
            end else if (rbuf_rd) begin
                done <= 1'b0;
                err  <= 1'b0;
            end
            if (tx_valid && tx_ready) begin
                tx_valid <= 1'b0;
                ready    <= 1'b1;
            end
            if (wr_en) begin
                case (reg_sel)
                    OFF_RCSR: rx_ie <= ~bus.pin_ad_in_n[BIT_IE];
                    OFF_XCSR: tx_ie <= ~bus.pin_ad_in_n[BIT_IE];
                    OFF_XBUF: begin
                        tx_data  <= ~bus.pin_ad_in_n[7:0];
                        tx_valid <= 1'b1;
                        ready    <= 1'b0;
                    end
                    default: ;
                endcase
            end
            // Requests set on the rising edge of flag&IE, drop with the condition
            // or when their vector is delivered.
            rx_cond_q <= rx_cond;
            tx_cond_q <= tx_cond;
            rq_rx     <= rx_cond && ((rq_rx && !clr_rx) || !rx_cond_q);
            rq_tx     <= tx_cond && ((rq_tx && !clr_tx) || !tx_cond_q);
        end
    end

    assign bus.pin_ad_oe    = ad_oe_q;
    assign bus.pin_ad_out_n = ad_out_q;
    assign bus.pin_rply_n   = rply_q;
    assign bus.pin_iako_n   = iako_q;
    assign bus.pin_virq_n   = !(rq_rx || rq_tx);

endmodule

// File: tb/tb_qbus_dl11.sv
module tb_qbus_dl11;

    logic       pin_clk = 1'b0;
    logic       pin_rst = 1'b1;
    logic [7:0] rx_data;
    logic       rx_stb;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    int checks   = 0;
    int failures = 0;

    qbus_dl11_if bus();

    qbus_dl11 dut (
        .pin_clk  (pin_clk),
        .pin_rst  (pin_rst),
        .bus      (bus),
        .rx_data  (rx_data),
        .rx_stb   (rx_stb),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready)
    );

    always #5 pin_clk = ~pin_clk;

    task automatic tick(input int n);
        repeat (n) @(negedge pin_clk);
    endtask

    task automatic bus_idle();
        bus.pin_ad_in_n = '1;
        bus.pin_sync_n  = 1'b1;
        bus.pin_din_n   = 1'b1;
        bus.pin_dout_n  = 1'b1;
        bus.pin_wtbt_n  = 1'b1;
        bus.pin_iaki_n  = 1'b1;
    endtask

    task automatic wait_rply(input logic level, input string what);
        int n;
        n = 0;
        while (bus.pin_rply_n !== level && n < 12) begin
            tick(1);
            n++;
        end
        checks++;
        if (bus.pin_rply_n !== level) begin
            failures++;
            $display("FAIL %s: rply_n=%b after timeout, required %b", what, bus.pin_rply_n, level);
        end
    endtask

    task automatic start_cycle(input logic [15:0] addr);
        bus.pin_ad_in_n = ~addr;
        bus.pin_sync_n  = 1'b0;
        tick(3);
        bus.pin_ad_in_n = '1;
    endtask

    task automatic end_cycle();
        bus_idle();
        tick(4);
    endtask

    task automatic do_read(input logic [15:0] addr, output logic [15:0] data);
        start_cycle(addr);
        bus.pin_din_n = 1'b0;
        wait_rply(1'b0, "read_rply");
        data = ~bus.pin_ad_out_n;
        bus.pin_din_n = 1'b1;
        wait_rply(1'b1, "read_release");
        end_cycle();
    endtask

    task automatic do_write(input logic [15:0] addr, input logic [15:0] data, input logic wtbt_n);
        start_cycle(addr);
        bus.pin_wtbt_n  = wtbt_n;
        bus.pin_ad_in_n = ~data;
        bus.pin_dout_n  = 1'b0;
        wait_rply(1'b0, "write_rply");
        bus.pin_dout_n = 1'b1;
        wait_rply(1'b1, "write_release");
        end_cycle();
    endtask

    task automatic do_iak(output logic [15:0] vec);
        bus.pin_din_n  = 1'b0;
        bus.pin_iaki_n = 1'b0;
        wait_rply(1'b0, "iak_rply");
        vec = ~bus.pin_ad_out_n;
        bus.pin_din_n  = 1'b1;
        bus.pin_iaki_n = 1'b1;
        wait_rply(1'b1, "iak_release");
        end_cycle();
    endtask

    task automatic pulse_rx(input logic [7:0] d);
        rx_data = d;
        rx_stb  = 1'b1;
        tick(1);
        rx_stb  = 1'b0;
        tick(1);
    endtask

    task automatic pulse_tx_ready();
        tx_ready = 1'b1;
        tick(1);
        tx_ready = 1'b0;
        tick(1);
    endtask

    task automatic test_reset();
        bus_idle();
        rx_stb   = 1'b0;
        rx_data  = '0;
        tx_ready = 1'b0;
        pin_rst  = 1'b1;
        tick(3);
        checks += 7;
        if (bus.pin_ad_oe !== 1'b0) begin failures++; $display("FAIL rst_ad_oe: got %b want 0", bus.pin_ad_oe); end
        if (bus.pin_ad_out_n !== 16'hFFFF) begin failures++; $display("FAIL rst_ad_out: got %h want ffff", bus.pin_ad_out_n); end
        if (bus.pin_rply_n !== 1'b1) begin failures++; $display("FAIL rst_rply: got %b want 1", bus.pin_rply_n); end
        if (bus.pin_virq_n !== 1'b1) begin failures++; $display("FAIL rst_virq: got %b want 1", bus.pin_virq_n); end
        if (bus.pin_iako_n !== 1'b1) begin failures++; $display("FAIL rst_iako: got %b want 1", bus.pin_iako_n); end
        if (tx_valid !== 1'b0) begin failures++; $display("FAIL rst_tx_valid: got %b want 0", tx_valid); end
        if (tx_data !== 8'h00) begin failures++; $display("FAIL rst_tx_data: got %h want 00", tx_data); end
        pin_rst = 1'b0;
        tick(3);
    endtask

    task automatic test_read_timing();
        logic [15:0] d;
        start_cycle(16'o177564);
        bus.pin_din_n = 1'b0;
        tick(2);
        checks++;
        if (bus.pin_ad_oe !== 1'b0) begin failures++; $display("FAIL rd_oe_early: got %b want 0", bus.pin_ad_oe); end
        tick(1);
        checks += 3;
        if (bus.pin_ad_oe !== 1'b1) begin failures++; $display("FAIL rd_oe: got %b want 1", bus.pin_ad_oe); end
        if (bus.pin_ad_out_n !== ~16'o000200) begin failures++; $display("FAIL rd_xcsr_data: got %o want %o", ~bus.pin_ad_out_n, 16'o000200); end
        if (bus.pin_rply_n !== 1'b1) begin failures++; $display("FAIL rd_rply_early: got %b want 1", bus.pin_rply_n); end
        tick(1);
        checks++;
        if (bus.pin_rply_n !== 1'b0) begin failures++; $display("FAIL rd_rply: got %b want 0", bus.pin_rply_n); end
        bus.pin_din_n = 1'b1;
        tick(2);
        checks++;
        if (bus.pin_rply_n !== 1'b0) begin failures++; $display("FAIL rd_hold: got %b want 0", bus.pin_rply_n); end
        tick(1);
        checks += 2;
        if (bus.pin_rply_n !== 1'b1) begin failures++; $display("FAIL rd_release_rply: got %b want 1", bus.pin_rply_n); end
        if (bus.pin_ad_oe !== 1'b0) begin failures++; $display("FAIL rd_release_oe: got %b want 0", bus.pin_ad_oe); end
        end_cycle();
        do_read(16'o177560, d);
        checks++;
        if (d !== 16'o000000) begin failures++; $display("FAIL rd_rcsr_reset: got %o want 0", d); end
    endtask

    task automatic test_tx();
        logic [15:0] d;
        start_cycle(16'o177566);
        bus.pin_ad_in_n = ~16'o000101;
        bus.pin_dout_n  = 1'b0;
        tick(2);
        checks += 2;
        if (bus.pin_rply_n !== 1'b1) begin failures++; $display("FAIL wr_rply_early: got %b want 1", bus.pin_rply_n); end
        if (tx_valid !== 1'b0) begin failures++; $display("FAIL wr_valid_early: got %b want 0", tx_valid); end
        tick(1);
        checks += 3;
        if (bus.pin_rply_n !== 1'b0) begin failures++; $display("FAIL wr_rply: got %b want 0", bus.pin_rply_n); end
        if (tx_valid !== 1'b1) begin failures++; $display("FAIL wr_tx_valid: got %b want 1", tx_valid); end
        if (tx_data !== 8'o101) begin failures++; $display("FAIL wr_tx_data: got %o want 101", tx_data); end
        bus.pin_dout_n = 1'b1;
        wait_rply(1'b1, "wr_release");
        end_cycle();
        do_read(16'o177564, d);
        checks++;
        if (d !== 16'o000000) begin failures++; $display("FAIL xcsr_busy: got %o want 0", d); end
        pulse_tx_ready();
        checks++;
        if (tx_valid !== 1'b0) begin failures++; $display("FAIL tx_valid_drop: got %b want 0", tx_valid); end
        do_read(16'o177564, d);
        checks++;
        if (d !== 16'o000200) begin failures++; $display("FAIL xcsr_ready: got %o want 200", d); end
    endtask

    task automatic test_tx_irq();
        do_write(16'o177564, 16'o000100, 1'b1);
        checks++;
        if (bus.pin_virq_n !== 1'b0) begin failures++; $display("FAIL tx_virq: got %b want 0", bus.pin_virq_n); end
        bus.pin_din_n  = 1'b0;
        bus.pin_iaki_n = 1'b0;
        tick(3);
        checks += 3;
        if (bus.pin_ad_oe !== 1'b1) begin failures++; $display("FAIL iak_oe: got %b want 1", bus.pin_ad_oe); end
        if (bus.pin_ad_out_n !== ~16'o000064) begin failures++; $display("FAIL iak_tx_vec: got %o want 64", ~bus.pin_ad_out_n); end
        if (bus.pin_rply_n !== 1'b1) begin failures++; $display("FAIL iak_rply_early: got %b want 1", bus.pin_rply_n); end
        tick(1);
        checks += 3;
        if (bus.pin_rply_n !== 1'b0) begin failures++; $display("FAIL iak_rply: got %b want 0", bus.pin_rply_n); end
        if (bus.pin_virq_n !== 1'b1) begin failures++; $display("FAIL iak_virq_clr: got %b want 1", bus.pin_virq_n); end
        if (bus.pin_iako_n !== 1'b1) begin failures++; $display("FAIL iak_no_pass: got %b want 1", bus.pin_iako_n); end
        bus.pin_din_n  = 1'b1;
        bus.pin_iaki_n = 1'b1;
        wait_rply(1'b1, "iak_release");
        end_cycle();
        checks++;
        if (bus.pin_virq_n !== 1'b1) begin failures++; $display("FAIL iak_virq_stays: got %b want 1", bus.pin_virq_n); end
        do_write(16'o177564, 16'o000000, 1'b1);
    endtask

    task automatic test_rx();
        logic [15:0] d;
        pulse_rx(8'h41);
        tick(2);
        pulse_rx(8'h41);
        do_read(16'o177560, d);
        checks++;
        if (d !== 16'o000200) begin failures++; $display("FAIL rcsr_done: got %o want 200", d); end
        do_read(16'o177562, d);
        checks++;
        if (d !== 16'o100101) begin failures++; $display("FAIL rbuf_overrun: got %o want 100101", d); end
        do_read(16'o177560, d);
        checks++;
        if (d !== 16'o000000) begin failures++; $display("FAIL rcsr_cleared: got %o want 0", d); end
        do_read(16'o177562, d);
        checks++;
        if (d !== 16'o000101) begin failures++; $display("FAIL rbuf_err_cleared: got %o want 101", d); end
        pulse_rx(8'h5A);
        checks++;
        if (bus.pin_virq_n !== 1'b1) begin failures++; $display("FAIL rx_no_ie_virq: got %b want 1", bus.pin_virq_n); end
        do_write(16'o177560, 16'o000100, 1'b1);
        checks++;
        if (bus.pin_virq_n !== 1'b0) begin failures++; $display("FAIL rx_ie_virq: got %b want 0", bus.pin_virq_n); end
        do_read(16'o177560, d);
        checks++;
        if (d !== 16'o000300) begin failures++; $display("FAIL rcsr_ie_done: got %o want 300", d); end
    endtask

    task automatic test_priority();
        logic [15:0] v;
        logic [15:0] d;
        do_write(16'o177564, 16'o000100, 1'b1);
        do_iak(v);
        checks += 2;
        if (v !== 16'o000060) begin failures++; $display("FAIL prio_first_vec: got %o want 60", v); end
        if (bus.pin_virq_n !== 1'b0) begin failures++; $display("FAIL prio_tx_left: got %b want 0", bus.pin_virq_n); end
        do_iak(v);
        checks += 2;
        if (v !== 16'o000064) begin failures++; $display("FAIL prio_second_vec: got %o want 64", v); end
        if (bus.pin_virq_n !== 1'b1) begin failures++; $display("FAIL prio_all_clear: got %b want 1", bus.pin_virq_n); end
        do_read(16'o177562, d);
        checks++;
        if (d !== 16'o000132) begin failures++; $display("FAIL prio_rbuf: got %o want 132", d); end
        do_write(16'o177560, 16'o000000, 1'b1);
        do_write(16'o177564, 16'o000000, 1'b1);
    endtask

    task automatic test_rx_collision();
        logic [15:0] d;
        pulse_rx(8'h11);
        tick(1);
        pulse_rx(8'h22);
        start_cycle(16'o177562);
        bus.pin_din_n = 1'b0;
        tick(3);
        rx_data = 8'h33;
        rx_stb  = 1'b1;
        tick(1);
        rx_stb  = 1'b0;
        checks += 2;
        if (bus.pin_rply_n !== 1'b0) begin failures++; $display("FAIL coll_rply: got %b want 0", bus.pin_rply_n); end
        if (bus.pin_ad_out_n !== ~16'h8022) begin failures++; $display("FAIL coll_old_data: got %h want 8022", ~bus.pin_ad_out_n); end
        bus.pin_din_n = 1'b1;
        wait_rply(1'b1, "coll_release");
        end_cycle();
        do_read(16'o177560, d);
        checks++;
        if (d !== 16'o000200) begin failures++; $display("FAIL coll_done_kept: got %o want 200", d); end
        do_read(16'o177562, d);
        checks++;
        if (d !== 16'h0033) begin failures++; $display("FAIL coll_new_data: got %h want 0033", d); end
    endtask

    task automatic test_pass();
        logic saw_rply;
        saw_rply = 1'b0;
        bus.pin_din_n  = 1'b0;
        bus.pin_iaki_n = 1'b0;
        tick(2);
        checks++;
        if (bus.pin_iako_n !== 1'b1) begin failures++; $display("FAIL pass_early: got %b want 1", bus.pin_iako_n); end
        tick(1);
        checks++;
        if (bus.pin_iako_n !== 1'b0) begin failures++; $display("FAIL pass_iako: got %b want 0", bus.pin_iako_n); end
        for (int i = 0; i < 6; i++) begin
            tick(1);
            if (bus.pin_rply_n !== 1'b1 || bus.pin_ad_oe !== 1'b0) saw_rply = 1'b1;
        end
        checks++;
        if (saw_rply !== 1'b0) begin failures++; $display("FAIL pass_no_rply: got %b want 0", saw_rply); end
        bus.pin_din_n  = 1'b1;
        bus.pin_iaki_n = 1'b1;
        tick(2);
        checks++;
        if (bus.pin_iako_n !== 1'b0) begin failures++; $display("FAIL pass_hold: got %b want 0", bus.pin_iako_n); end
        tick(1);
        checks++;
        if (bus.pin_iako_n !== 1'b1) begin failures++; $display("FAIL pass_release: got %b want 1", bus.pin_iako_n); end
        end_cycle();
    endtask

    task automatic test_unselected();
        logic seen_oe;
        logic seen_rply;
        seen_oe   = 1'b0;
        seen_rply = 1'b0;
        start_cycle(16'o177570);
        bus.pin_din_n = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (bus.pin_ad_oe !== 1'b0) seen_oe = 1'b1;
            if (bus.pin_rply_n !== 1'b1) seen_rply = 1'b1;
        end
        bus.pin_din_n   = 1'b1;
        tick(3);
        bus.pin_ad_in_n = ~16'h00AA;
        bus.pin_dout_n  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (bus.pin_ad_oe !== 1'b0) seen_oe = 1'b1;
            if (bus.pin_rply_n !== 1'b1) seen_rply = 1'b1;
        end
        end_cycle();
        checks += 3;
        if (seen_oe !== 1'b0) begin failures++; $display("FAIL unsel_ad_oe: got %b want 0", seen_oe); end
        if (seen_rply !== 1'b0) begin failures++; $display("FAIL unsel_rply: got %b want 0", seen_rply); end
        if (tx_valid !== 1'b0) begin failures++; $display("FAIL unsel_tx_valid: got %b want 0", tx_valid); end
    endtask

    task automatic test_byte_write();
        do_write(16'o177567, 16'h0041, 1'b0);
        checks++;
        if (tx_valid !== 1'b0) begin failures++; $display("FAIL odd_byte_ignored: got %b want 0", tx_valid); end
        do_write(16'o177566, 16'h1255, 1'b0);
        checks += 2;
        if (tx_valid !== 1'b1) begin failures++; $display("FAIL even_byte_valid: got %b want 1", tx_valid); end
        if (tx_data !== 8'h55) begin failures++; $display("FAIL even_byte_data: got %h want 55", tx_data); end
        do_write(16'o177566, 16'h0066, 1'b1);
        checks += 2;
        if (tx_data !== 8'h66) begin failures++; $display("FAIL overwrite_data: got %h want 66", tx_data); end
        if (tx_valid !== 1'b1) begin failures++; $display("FAIL overwrite_valid: got %b want 1", tx_valid); end
        pulse_tx_ready();
    endtask

    task automatic test_reset_mid();
        logic [15:0] d;
        do_write(16'o177566, 16'h007F, 1'b1);
        do_write(16'o177560, 16'o000100, 1'b1);
        checks++;
        if (tx_valid !== 1'b1) begin failures++; $display("FAIL mid_setup_valid: got %b want 1", tx_valid); end
        start_cycle(16'o177564);
        bus.pin_din_n = 1'b0;
        tick(3);
        checks++;
        if (bus.pin_ad_oe !== 1'b1) begin failures++; $display("FAIL mid_oe_before: got %b want 1", bus.pin_ad_oe); end
        #2 pin_rst = 1'b1;
        #1;
        checks += 3;
        if (bus.pin_ad_oe !== 1'b0) begin failures++; $display("FAIL mid_oe: got %b want 0", bus.pin_ad_oe); end
        if (bus.pin_rply_n !== 1'b1) begin failures++; $display("FAIL mid_rply: got %b want 1", bus.pin_rply_n); end
        if (bus.pin_ad_out_n !== 16'hFFFF) begin failures++; $display("FAIL mid_ad_out: got %h want ffff", bus.pin_ad_out_n); end
        tick(1);
        bus_idle();
        tick(2);
        checks += 2;
        if (tx_valid !== 1'b0) begin failures++; $display("FAIL mid_tx_valid: got %b want 0", tx_valid); end
        if (tx_data !== 8'h00) begin failures++; $display("FAIL mid_tx_data: got %h want 00", tx_data); end
        pin_rst = 1'b0;
        tick(3);
        do_read(16'o177564, d);
        checks++;
        if (d !== 16'o000200) begin failures++; $display("FAIL mid_xcsr: got %o want 200", d); end
        do_read(16'o177560, d);
        checks += 2;
        if (d !== 16'o000000) begin failures++; $display("FAIL mid_rcsr: got %o want 0", d); end
        if (bus.pin_virq_n !== 1'b1) begin failures++; $display("FAIL mid_virq: got %b want 1", bus.pin_virq_n); end
    endtask

    initial begin
        test_reset();
        test_read_timing();
        test_tx();
        test_tx_irq();
        test_rx();
        test_priority();
        test_rx_collision();
        test_pass();
        test_unselected();
        test_byte_write();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
